// File: rtl/bus_pkg.sv
// ---------------------------------------------------------------------------
// bus_pkg
//   Shared definitions for the simple valid/ready bus slave:
//     BUS_ADDR_W / BUS_DATA_W : default address and data widths
//     bus_state_e             : slave FSM state encoding (IDLE, WAIT, RESP)
//     ERR_RDATA               : read data returned for out-of-range reads
// ---------------------------------------------------------------------------
package bus_pkg;

  localparam int unsigned BUS_ADDR_W = 8;
  localparam int unsigned BUS_DATA_W = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } bus_state_e;

  localparam logic [BUS_DATA_W-1:0] ERR_RDATA = '0;

endpackage : bus_pkg

// File: rtl/bus_slave_regfile.sv
// ---------------------------------------------------------------------------
// bus_slave_regfile
//   DEPTH x DATA_W storage array, cleared by asynchronous reset.
//   One synchronous write port and one registered read port. The read
//   register holds its value until the next read; rzero_i loads ERR_RDATA
//   instead of an array word.
//
//   Ports:
//     clk      in   clock, all state on rising edge
//     rst_n    in   asynchronous active-low reset (array and read reg to 0)
//     we_i     in   write enable
//     waddr_i  in   write word index
//     wdata_i  in   write data
//     re_i     in   read enable (updates rdata_o on next edge)
//     rzero_i  in   with re_i: load ERR_RDATA instead of array contents
//     raddr_i  in   read word index
//     rdata_o  out  registered read data
// ---------------------------------------------------------------------------
module bus_slave_regfile
  import bus_pkg::*;
#(
  parameter int unsigned DATA_W = BUS_DATA_W,
  parameter int unsigned DEPTH  = 64,
  parameter int unsigned IDX_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we_i,
  input  logic [IDX_W-1:0]  waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic              re_i,
  input  logic              rzero_i,
  input  logic [IDX_W-1:0]  raddr_i,
  output logic [DATA_W-1:0] rdata_o
);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] rdata_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata_q <= '0;
    end else if (re_i) begin
      rdata_q <= rzero_i ? DATA_W'(ERR_RDATA) : mem_q[raddr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule : bus_slave_regfile

// File: rtl/bus_slave_mem.sv
// ---------------------------------------------------------------------------
// bus_slave_mem
//   Memory-backed slave on the simple valid/ready bus. Accepts a request in
//   IDLE, waits WAIT_CYCLES cycles, then completes it with a one-cycle ready
//   pulse. Out-of-range addresses (addr >= DEPTH) complete with err=1 and no
//   side effects other than rdata=0 on reads.
//
//   Ports:
//     clk       in   bus clock, all state on rising edge
//     rst_n     in   asynchronous active-low reset
//     valid     in   request valid, held by the manager until ready
//     wr_en     in   1 = write, 0 = read
//     addr      in   word address
//     wdata     in   write data
//     rdata     out  read data, valid with ready and held afterwards
//     ready     out  one-cycle completion pulse
//     err       out  out-of-range flag, valid with ready
//     wr_count  out  completed in-range writes (wraps)
//     rd_count  out  completed in-range reads (wraps)
// ---------------------------------------------------------------------------
module bus_slave_mem
  import bus_pkg::*;
#(
  parameter int unsigned ADDR_W      = BUS_ADDR_W,
  parameter int unsigned DATA_W      = BUS_DATA_W,
  parameter int unsigned DEPTH       = 64,
  parameter int unsigned WAIT_CYCLES = 2,
  parameter int unsigned CNT_W       = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              valid,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata,
  output logic              ready,
  output logic              err,
  output logic [CNT_W-1:0]  wr_count,
  output logic [CNT_W-1:0]  rd_count
);

  localparam int unsigned IDX_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned WCNT_W = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;

  localparam logic [WCNT_W-1:0] WAIT_LOAD = WCNT_W'(WAIT_CYCLES);
  localparam logic [ADDR_W:0]   DEPTH_X   = (ADDR_W + 1)'(DEPTH);

  // ---------------------------------------------------------------------
  // State and registers
  // ---------------------------------------------------------------------
  bus_state_e state_q, state_d;

  logic              wr_en_q,    wr_en_d;
  logic [ADDR_W-1:0] addr_q,     addr_d;
  logic [DATA_W-1:0] wdata_q,    wdata_d;
  logic [WCNT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic              ready_q,    ready_d;
  logic              err_q,      err_d;
  logic [CNT_W-1:0]  wr_count_q, wr_count_d;
  logic [CNT_W-1:0]  rd_count_q, rd_count_d;

  logic              accept;
  logic              enter_resp;
  logic              in_range;
  logic              mem_we;
  logic              mem_re;
  logic              mem_rzero;
  logic [IDX_W-1:0]  mem_idx;
  logic [DATA_W-1:0] mem_rdata;

  // ---------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------------------------------------------------------------
  // FSM: next-state logic
  // ---------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (valid) begin
          state_d = (WAIT_CYCLES > 0) ? WAIT : RESP;
        end
      end
      WAIT: begin
        // Counter reaches zero on this edge: complete now.
        if (wait_cnt_q == WCNT_W'(1)) begin
          state_d = RESP;
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------
  // FSM: output / datapath logic
  // ---------------------------------------------------------------------
  always_comb begin
    wr_en_d    = wr_en_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    wait_cnt_d = wait_cnt_q;
    wr_count_d = wr_count_q;
    rd_count_d = rd_count_q;

    accept = (state_q == IDLE) && valid;

    if (accept) begin
      wr_en_d    = wr_en;
      addr_d     = addr;
      wdata_d    = wdata;
      wait_cnt_d = WAIT_LOAD;
    end else if (state_q == WAIT) begin
      wait_cnt_d = wait_cnt_q - WCNT_W'(1);
    end

    // The request is taken from the _d fields: with zero wait states the
    // acceptance edge is also the completion edge, so the live bus fields
    // are used before they have been captured into _q.
    enter_resp = (state_d == RESP);
    in_range   = ({1'b0, addr_d} < DEPTH_X);

    ready_d = enter_resp;
    err_d   = enter_resp && !in_range;

    mem_we    = enter_resp && wr_en_d && in_range;
    mem_re    = enter_resp && !wr_en_d;
    mem_rzero = !in_range;
    mem_idx   = addr_d[IDX_W-1:0];

    if (enter_resp && in_range) begin
      if (wr_en_d) begin
        wr_count_d = wr_count_q + CNT_W'(1);
      end else begin
        rd_count_d = rd_count_q + CNT_W'(1);
      end
    end
  end

  // ---------------------------------------------------------------------
  // Request capture, wait counter and registered outputs
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_en_q    <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      wait_cnt_q <= '0;
      ready_q    <= 1'b0;
      err_q      <= 1'b0;
      wr_count_q <= '0;
      rd_count_q <= '0;
    end else begin
      wr_en_q    <= wr_en_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      wait_cnt_q <= wait_cnt_d;
      ready_q    <= ready_d;
      err_q      <= err_d;
      wr_count_q <= wr_count_d;
      rd_count_q <= rd_count_d;
    end
  end

  // ---------------------------------------------------------------------
  // Storage
  // ---------------------------------------------------------------------
  bus_slave_regfile #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .IDX_W  (IDX_W)
  ) u_regfile (
    .clk     (clk),
    .rst_n   (rst_n),
    .we_i    (mem_we),
    .waddr_i (mem_idx),
    .wdata_i (wdata_d),
    .re_i    (mem_re),
    .rzero_i (mem_rzero),
    .raddr_i (mem_idx),
    .rdata_o (mem_rdata)
  );

  assign rdata    = mem_rdata;
  assign ready    = ready_q;
  assign err      = err_q;
  assign wr_count = wr_count_q;
  assign rd_count = rd_count_q;

endmodule : bus_slave_mem

// File: tb/tb_bus_slave_mem.sv
// ---------------------------------------------------------------------------
// tb_bus_slave_mem
//   Directed bench for bus_slave_mem. Instance u_dut uses the default
//   parameters (WAIT_CYCLES=2, DEPTH=64); instance u_dut_w0 uses
//   WAIT_CYCLES=0 and CNT_W=4 for back-to-back and counter-wrap scenarios.
//   Inputs are driven and outputs sampled on the falling clock edge.
// ---------------------------------------------------------------------------
module tb_bus_slave_mem;

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  logic        a_valid, a_wr_en;
  logic [7:0]  a_addr;
  logic [31:0] a_wdata, a_rdata;
  logic        a_ready, a_err;
  logic [15:0] a_wr_count, a_rd_count;

  logic        b_valid, b_wr_en;
  logic [7:0]  b_addr;
  logic [31:0] b_wdata, b_rdata;
  logic        b_ready, b_err;
  logic [3:0]  b_wr_count, b_rd_count;

  int checks = 0;
  int errors = 0;

  bus_slave_mem #(
    .ADDR_W      (8),
    .DATA_W      (32),
    .DEPTH       (64),
    .WAIT_CYCLES (2),
    .CNT_W       (16)
  ) u_dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .valid    (a_valid),
    .wr_en    (a_wr_en),
    .addr     (a_addr),
    .wdata    (a_wdata),
    .rdata    (a_rdata),
    .ready    (a_ready),
    .err      (a_err),
    .wr_count (a_wr_count),
    .rd_count (a_rd_count)
  );

  bus_slave_mem #(
    .ADDR_W      (8),
    .DATA_W      (32),
    .DEPTH       (64),
    .WAIT_CYCLES (0),
    .CNT_W       (4)
  ) u_dut_w0 (
    .clk      (clk),
    .rst_n    (rst_n),
    .valid    (b_valid),
    .wr_en    (b_wr_en),
    .addr     (b_addr),
    .wdata    (b_wdata),
    .rdata    (b_rdata),
    .ready    (b_ready),
    .err      (b_err),
    .wr_count (b_wr_count),
    .rd_count (b_rd_count)
  );

  // Drives one transaction on instance A (use_b=0) or B (use_b=1).
  // lat counts falling-edge samples after the acceptance edge until ready
  // is seen (0 = never seen within the budget). rdy_after is ready one
  // cycle after the pulse.
  task automatic xact(input bit use_b, input logic wr, input logic [7:0] ad,
                      input logic [31:0] wd, output int lat,
                      output logic [31:0] rd, output logic er,
                      output logic rdy_after);
    lat       = 0;
    rd        = '0;
    er        = 1'b0;
    rdy_after = 1'b1;
    @(negedge clk);
    if (use_b) begin
      b_valid = 1'b1; b_wr_en = wr; b_addr = ad; b_wdata = wd;
    end else begin
      a_valid = 1'b1; a_wr_en = wr; a_addr = ad; a_wdata = wd;
    end
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      if ((use_b ? b_ready : a_ready) === 1'b1) begin
        lat = k;
        rd  = use_b ? b_rdata : a_rdata;
        er  = use_b ? b_err : a_err;
        break;
      end
    end
    a_valid = 1'b0;
    b_valid = 1'b0;
    @(negedge clk);
    rdy_after = use_b ? b_ready : a_ready;
  endtask

  task automatic test_reset();
    rst_n = 1'b1;
    a_valid = 1'b0; a_wr_en = 1'b0; a_addr = '0; a_wdata = '0;
    b_valid = 1'b0; b_wr_en = 1'b0; b_addr = '0; b_wdata = '0;
    #2 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if (a_ready !== 1'b0) begin errors++; $display("FAIL reset_ready: got %b expected 0", a_ready); end
    checks++; if (a_err !== 1'b0) begin errors++; $display("FAIL reset_err: got %b expected 0", a_err); end
    checks++; if (a_rdata !== 32'h0) begin errors++; $display("FAIL reset_rdata: got %h expected 0", a_rdata); end
    checks++; if (a_wr_count !== 16'd0) begin errors++; $display("FAIL reset_wr_count: got %0d expected 0", a_wr_count); end
    checks++; if (a_rd_count !== 16'd0) begin errors++; $display("FAIL reset_rd_count: got %0d expected 0", a_rd_count); end
    checks++; if (b_ready !== 1'b0) begin errors++; $display("FAIL reset_b_ready: got %b expected 0", b_ready); end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_write_read();
    int lat; logic [31:0] rd; logic er, ra;
    xact(1'b0, 1'b1, 8'h10, 32'hABCD_1234, lat, rd, er, ra);
    checks++; if (lat !== 3) begin errors++; $display("FAIL wr_latency: got %0d expected 3", lat); end
    checks++; if (er !== 1'b0) begin errors++; $display("FAIL wr_err: got %b expected 0", er); end
    checks++; if (ra !== 1'b0) begin errors++; $display("FAIL wr_ready_width: got %b expected 0", ra); end
    xact(1'b0, 1'b0, 8'h10, 32'h0, lat, rd, er, ra);
    checks++; if (lat !== 3) begin errors++; $display("FAIL rd_latency: got %0d expected 3", lat); end
    checks++; if (rd !== 32'hABCD_1234) begin errors++; $display("FAIL rd_data: got %h expected abcd1234", rd); end
    checks++; if (er !== 1'b0) begin errors++; $display("FAIL rd_err: got %b expected 0", er); end
    checks++; if (ra !== 1'b0) begin errors++; $display("FAIL rd_ready_width: got %b expected 0", ra); end
    checks++; if (a_wr_count !== 16'd1) begin errors++; $display("FAIL wr_count_1: got %0d expected 1", a_wr_count); end
    checks++; if (a_rd_count !== 16'd1) begin errors++; $display("FAIL rd_count_1: got %0d expected 1", a_rd_count); end
  endtask

  task automatic test_out_of_range();
    int lat; logic [31:0] rd; logic er, ra;
    xact(1'b0, 1'b1, 8'h40, 32'h0000_0055, lat, rd, er, ra);
    checks++; if (lat !== 3) begin errors++; $display("FAIL oor_wr_latency: got %0d expected 3", lat); end
    checks++; if (er !== 1'b1) begin errors++; $display("FAIL oor_wr_err: got %b expected 1", er); end
    xact(1'b0, 1'b0, 8'h40, 32'h0, lat, rd, er, ra);
    checks++; if (er !== 1'b1) begin errors++; $display("FAIL oor_rd_err: got %b expected 1", er); end
    checks++; if (rd !== 32'h0) begin errors++; $display("FAIL oor_rd_data: got %h expected 0", rd); end
    checks++; if (a_wr_count !== 16'd1) begin errors++; $display("FAIL oor_wr_count: got %0d expected 1", a_wr_count); end
    checks++; if (a_rd_count !== 16'd1) begin errors++; $display("FAIL oor_rd_count: got %0d expected 1", a_rd_count); end
    xact(1'b0, 1'b0, 8'h00, 32'h0, lat, rd, er, ra);
    checks++; if (rd !== 32'h0) begin errors++; $display("FAIL oor_alias_mem0: got %h expected 0", rd); end
    checks++; if (er !== 1'b0) begin errors++; $display("FAIL mem0_err: got %b expected 0", er); end
    checks++; if (a_rd_count !== 16'd2) begin errors++; $display("FAIL mem0_rd_count: got %0d expected 2", a_rd_count); end
  endtask

  task automatic test_field_stability();
    int lat; logic [31:0] rd; logic er, ra;
    @(negedge clk);
    a_valid = 1'b1; a_wr_en = 1'b1; a_addr = 8'h05; a_wdata = 32'h0000_1111;
    @(negedge clk);
    checks++; if (a_ready !== 1'b0) begin errors++; $display("FAIL fs_wait1_ready: got %b expected 0", a_ready); end
    a_addr = 8'h06; a_wdata = 32'h0000_2222; a_wr_en = 1'b0;
    @(negedge clk);
    checks++; if (a_ready !== 1'b0) begin errors++; $display("FAIL fs_wait2_ready: got %b expected 0", a_ready); end
    a_valid = 1'b0;
    @(negedge clk);
    checks++; if (a_ready !== 1'b1) begin errors++; $display("FAIL fs_ready_no_abort: got %b expected 1", a_ready); end
    checks++; if (a_err !== 1'b0) begin errors++; $display("FAIL fs_err: got %b expected 0", a_err); end
    @(negedge clk);
    checks++; if (a_ready !== 1'b0) begin errors++; $display("FAIL fs_ready_drop: got %b expected 0", a_ready); end
    checks++; if (a_wr_count !== 16'd2) begin errors++; $display("FAIL fs_wr_count: got %0d expected 2", a_wr_count); end
    xact(1'b0, 1'b0, 8'h06, 32'h0, lat, rd, er, ra);
    checks++; if (rd !== 32'h0) begin errors++; $display("FAIL fs_mem6: got %h expected 0", rd); end
    xact(1'b0, 1'b0, 8'h05, 32'h0, lat, rd, er, ra);
    checks++; if (rd !== 32'h0000_1111) begin errors++; $display("FAIL fs_mem5: got %h expected 00001111", rd); end
    checks++; if (a_rd_count !== 16'd4) begin errors++; $display("FAIL fs_rd_count: got %0d expected 4", a_rd_count); end
  endtask

  task automatic test_reset_mid_op();
    int lat; logic [31:0] rd; logic er, ra;
    @(negedge clk);
    a_valid = 1'b1; a_wr_en = 1'b1; a_addr = 8'h08; a_wdata = 32'hDEAD_BEEF;
    @(negedge clk);
    rst_n = 1'b0;
    a_valid = 1'b0;
    #1;
    checks++; if (a_ready !== 1'b0) begin errors++; $display("FAIL rst_mid_ready: got %b expected 0", a_ready); end
    checks++; if (a_err !== 1'b0) begin errors++; $display("FAIL rst_mid_err: got %b expected 0", a_err); end
    checks++; if (a_rdata !== 32'h0) begin errors++; $display("FAIL rst_mid_rdata: got %h expected 0", a_rdata); end
    checks++; if (a_wr_count !== 16'd0) begin errors++; $display("FAIL rst_mid_wr_count: got %0d expected 0", a_wr_count); end
    @(negedge clk);
    rst_n = 1'b1;
    xact(1'b0, 1'b0, 8'h08, 32'h0, lat, rd, er, ra);
    checks++; if (lat !== 3) begin errors++; $display("FAIL rst_mid_rd_latency: got %0d expected 3", lat); end
    checks++; if (rd !== 32'h0) begin errors++; $display("FAIL rst_mid_mem8: got %h expected 0", rd); end
    checks++; if (a_wr_count !== 16'd0) begin errors++; $display("FAIL rst_mid_wr_after: got %0d expected 0", a_wr_count); end
    checks++; if (a_rd_count !== 16'd1) begin errors++; $display("FAIL rst_mid_rd_after: got %0d expected 1", a_rd_count); end
  endtask

  task automatic test_back_to_back();
    int lat; logic [31:0] rd; logic er, ra;
    logic [7:0] pat;
    int n;
    pat = '0;
    n   = 0;
    @(negedge clk);
    b_valid = 1'b1; b_wr_en = 1'b1; b_addr = 8'h00; b_wdata = 32'hC0DE_0000;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      pat[k] = b_ready;
      if (b_ready === 1'b1) begin
        n++;
        if (n == 4) begin
          b_valid = 1'b0;
        end else begin
          b_addr  = 8'(n);
          b_wdata = 32'hC0DE_0000 + 32'(n);
        end
      end
    end
    b_valid = 1'b0;
    checks++; if (pat !== 8'b0101_0101) begin errors++; $display("FAIL b2b_ready_pattern: got %b expected 01010101", pat); end
    checks++; if (b_wr_count !== 4'd4) begin errors++; $display("FAIL b2b_wr_count: got %0d expected 4", b_wr_count); end
    for (int i = 0; i < 4; i++) begin
      xact(1'b1, 1'b0, 8'(i), 32'h0, lat, rd, er, ra);
      checks++; if (lat !== 1) begin errors++; $display("FAIL b2b_rd_latency[%0d]: got %0d expected 1", i, lat); end
      checks++; if (rd !== 32'hC0DE_0000 + 32'(i)) begin errors++; $display("FAIL b2b_rd_data[%0d]: got %h expected %h", i, rd, 32'hC0DE_0000 + 32'(i)); end
    end
    checks++; if (b_rd_count !== 4'd4) begin errors++; $display("FAIL b2b_rd_count: got %0d expected 4", b_rd_count); end
  endtask

  task automatic test_counter_wrap();
    int lat; logic [31:0] rd; logic er, ra;
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 16; i++) begin
      xact(1'b1, 1'b0, 8'h03, 32'h0, lat, rd, er, ra);
    end
    checks++; if (b_rd_count !== 4'd0) begin errors++; $display("FAIL wrap_at_16: got %0d expected 0", b_rd_count); end
    xact(1'b1, 1'b0, 8'h03, 32'h0, lat, rd, er, ra);
    checks++; if (b_rd_count !== 4'd1) begin errors++; $display("FAIL wrap_at_17: got %0d expected 1", b_rd_count); end
    checks++; if (b_wr_count !== 4'd0) begin errors++; $display("FAIL wrap_wr_count: got %0d expected 0", b_wr_count); end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_out_of_range();
    test_field_stability();
    test_reset_mid_op();
    test_back_to_back();
    test_counter_wrap();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_bus_slave_mem
